// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle sequencing controller: opcodes,
// datapath select encodings and the FSM state enumeration.
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SHIFT = 6'b110000;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_AND   = 2'b11;

   localparam logic [1:0] ALU_SRC_B_REG      = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR     = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM      = 2'b10;
   localparam logic [1:0] ALU_SRC_B_IMM_SHL2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU     = 2'b00;
   localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EX     = 4'd7,
      S_SH_EX    = 4'd8,
      S_IMM_EX   = 4'd9,
      S_R_WB     = 4'd10,
      S_IMM_WB   = 4'd11,
      S_BRANCH   = 4'd12,
      S_JUMP     = 4'd13,
      S_HALT     = 4'd14
   } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the sequencing controller and the datapath: opcode and
// memory handshake in, datapath control strobes and status out.
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_source;
   logic             instr_done;
   logic             halted;
   logic [CNT_W-1:0] retired;
   logic [3:0]       state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, halted, retired, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, halted, retired, state
   );
endinterface

// File: rtl/mc_dispatch.sv
// DECODE dispatch ROM: maps the live opcode to the first state after DECODE.
module mc_dispatch
   import multicycle_control_pkg::*;
(
   input  logic [5:0] opcode,
   output state_t     next_state
);

   always_comb begin
      next_state = S_HALT;
      case (opcode)
         OP_RTYPE:        next_state = S_R_EX;
         OP_SHIFT:        next_state = S_SH_EX;
         OP_ADDI, OP_ANDI: next_state = S_IMM_EX;
         OP_LW, OP_SW:    next_state = S_MEM_ADDR;
         OP_BEQ:          next_state = S_BRANCH;
         OP_J:            next_state = S_JUMP;
         default:         next_state = S_HALT;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback over a shared memory port.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_control_if.master bus
);

   state_t           state_reg;
   state_t           state_next;
   state_t           decode_next;
   logic [5:0]       opcode_q_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             instr_done;

   mc_dispatch u_dispatch (
      .opcode     (bus.opcode),
      .next_state (decode_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_RST;
         opcode_q_reg <= '0;
         retired_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DECODE)
            opcode_q_reg <= bus.opcode;
         // Count on the edge that leaves the retiring state.
         if (instr_done)
            retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   always_comb begin
      state_next        = state_reg;
      instr_done        = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = ALU_SRC_B_REG;
      bus.alu_op        = ALU_OP_ADD;
      bus.pc_source     = PC_SRC_ALU;
      bus.halted        = 1'b0;
      case (state_reg)
         S_RST: state_next = S_FETCH;
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = ALU_SRC_B_FOUR;
            bus.pc_write  = bus.mem_ready;
            bus.ir_write  = bus.mem_ready;
            if (bus.mem_ready)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            bus.alu_src_b = ALU_SRC_B_IMM_SHL2;
            state_next    = decode_next;
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = ALU_SRC_B_IMM;
            state_next    = (opcode_q_reg == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            bus.iord     = 1'b1;
            bus.mem_read = 1'b1;
            if (bus.mem_ready)
               state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            bus.mem_to_reg = 1'b1;
            bus.reg_write  = 1'b1;
            instr_done     = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEM_WR: begin
            bus.iord      = 1'b1;
            bus.mem_write = 1'b1;
            instr_done    = bus.mem_ready;
            if (bus.mem_ready)
               state_next = S_FETCH;
         end
         S_R_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_OP_FUNCT;
            state_next    = S_R_WB;
         end
         S_SH_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = ALU_SRC_B_IMM;
            bus.alu_op    = ALU_OP_FUNCT;
            state_next    = S_R_WB;
         end
         S_IMM_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = ALU_SRC_B_IMM;
            bus.alu_op    = (opcode_q_reg == OP_ANDI) ? ALU_OP_AND : ALU_OP_ADD;
            state_next    = S_IMM_WB;
         end
         S_R_WB: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
            instr_done    = 1'b1;
            state_next    = S_FETCH;
         end
         S_IMM_WB: begin
            bus.reg_write = 1'b1;
            instr_done    = 1'b1;
            state_next    = S_FETCH;
         end
         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALU_OP_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = PC_SRC_ALU_OUT;
            instr_done        = 1'b1;
            state_next        = S_FETCH;
         end
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_SRC_JUMP;
            instr_done    = 1'b1;
            state_next    = S_FETCH;
         end
         S_HALT: bus.halted = 1'b1;
         default: state_next = S_FETCH;
      endcase
   end

   assign bus.instr_done = instr_done;
   assign bus.retired    = retired_reg;
   assign bus.state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: instruction-level reference model expands
// each opcode into its expected per-cycle control words and retire count.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;

   multicycle_control_if #(.CNT_W(CNT_W)) bus ();

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0]      w;
      logic [CNT_W-1:0] ret;
   } exp_t;

   typedef struct {
      int st;
      bit rdy;
   } ph_t;

   exp_t             exp_q[$];
   ph_t              seq_q[$];
   logic [CNT_W-1:0] model_cnt = '0;
   logic [5:0]       cur_opc = '0;
   int               n_checks = 0;
   int               n_errors = 0;

   logic [21:0] dut_word;
   assign dut_word = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.pc_source, bus.instr_done, bus.halted, bus.state};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Expected control word for one cycle, straight from the per-state output table.
   function automatic logic [21:0] exp_word(input int st, input logic [5:0] opc, input bit rdy);
      logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
      logic rd = 0, m2r = 0, rw = 0, asa = 0, done = 0, hlt = 0;
      logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
      case (st)
         1:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
         2:  asb = 2'b11;
         3:  begin asa = 1; asb = 2'b10; end
         4:  begin iord = 1; mr = 1; end
         5:  begin m2r = 1; rw = 1; done = 1; end
         6:  begin iord = 1; mw = 1; done = rdy; end
         7:  begin asa = 1; aop = 2'b10; end
         8:  begin asa = 1; asb = 2'b10; aop = 2'b10; end
         9:  begin asa = 1; asb = 2'b10; aop = (opc == 6'b001100) ? 2'b11 : 2'b00; end
         10: begin rd = 1; rw = 1; done = 1; end
         11: begin rw = 1; done = 1; end
         12: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
         13: begin pcw = 1; psrc = 2'b10; done = 1; end
         14: hlt = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc,
              done, hlt, 4'(st)};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b110000, 6'b001000, 6'b001100,
                        6'b100011, 6'b101011, 6'b000100, 6'b000010};
   endfunction

   // Single compare process: every cycle with a queued expectation is checked.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ctrl_word", 64'(dut_word), 64'(e.w));
         check("retired", 64'(bus.retired), 64'(e.ret));
      end
   end

   task automatic step(input int st, input bit rdy);
      exp_t e;
      @(negedge clk);
      bus.mem_ready = rdy;
      bus.opcode    = cur_opc;
      e.w   = exp_word(st, cur_opc, rdy);
      e.ret = model_cnt;
      exp_q.push_back(e);
      if (e.w[5])
         model_cnt++;
   endtask

   task automatic rst_cycle(input bit r);
      exp_t e;
      @(negedge clk);
      reset = r;
      bus.mem_ready = 1'b1;
      model_cnt = '0;
      e.w   = '0;
      e.ret = '0;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      repeat (3) rst_cycle(1'b0);
      rst_cycle(1'b1);
   endtask

   function automatic ph_t ph(input int st, input bit rdy);
      ph_t p;
      p.st  = st;
      p.rdy = rdy;
      return p;
   endfunction

   // Instruction-level model: phase list for one instruction with given wait states.
   task automatic build(input logic [5:0] opc, input int wf, input int wm, input int nhalt);
      seq_q.delete();
      repeat (wf) seq_q.push_back(ph(1, 1'b0));
      seq_q.push_back(ph(1, 1'b1));
      seq_q.push_back(ph(2, 1'($urandom_range(0, 1))));
      case (opc)
         6'b000000: begin seq_q.push_back(ph(7, 1'($urandom_range(0, 1)))); seq_q.push_back(ph(10, 1'($urandom_range(0, 1)))); end
         6'b110000: begin seq_q.push_back(ph(8, 1'($urandom_range(0, 1)))); seq_q.push_back(ph(10, 1'($urandom_range(0, 1)))); end
         6'b001000, 6'b001100: begin seq_q.push_back(ph(9, 1'($urandom_range(0, 1)))); seq_q.push_back(ph(11, 1'($urandom_range(0, 1)))); end
         6'b100011: begin
            seq_q.push_back(ph(3, 1'($urandom_range(0, 1))));
            repeat (wm) seq_q.push_back(ph(4, 1'b0));
            seq_q.push_back(ph(4, 1'b1));
            seq_q.push_back(ph(5, 1'($urandom_range(0, 1))));
         end
         6'b101011: begin
            seq_q.push_back(ph(3, 1'($urandom_range(0, 1))));
            repeat (wm) seq_q.push_back(ph(6, 1'b0));
            seq_q.push_back(ph(6, 1'b1));
         end
         6'b000100: seq_q.push_back(ph(12, 1'($urandom_range(0, 1))));
         6'b000010: seq_q.push_back(ph(13, 1'($urandom_range(0, 1))));
         default: repeat (nhalt) seq_q.push_back(ph(14, 1'($urandom_range(0, 1))));
      endcase
   endtask

   task automatic play(input int limit, output int ncyc);
      ph_t p;
      ncyc = 0;
      while (seq_q.size() > 0 && ncyc < limit) begin
         p = seq_q.pop_front();
         step(p.st, p.rdy);
         ncyc++;
      end
   endtask

   // Park in FETCH (or HALT) with mem_ready low so the DUT can be inspected.
   task automatic idle_peek();
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #3;
   endtask

   task automatic directed(input logic [5:0] opc, input int wm, input int len,
                           input string name);
      int n;
      cur_opc = opc;
      build(opc, 0, wm, 0);
      play(1000, n);
      check({name, "_len"}, 64'(n), 64'(len));
      $display("directed %s opcode=%b cycles=%0d", name, opc, n);
   endtask

   initial begin
      int n;
      logic [5:0] op;
      logic [5:0] legal_ops[8];
      legal_ops = '{6'b000000, 6'b110000, 6'b001000, 6'b001100,
                    6'b100011, 6'b101011, 6'b000100, 6'b000010};
      bus.opcode    = '0;
      bus.mem_ready = 1'b1;

      do_reset();

      directed(OP_RTYPE, 0, 4, "rtype");
      idle_peek();
      check("rtype_retired", 64'(bus.retired), 64'd1);
      directed(OP_LW, 2, 7, "lw_wait2");
      directed(OP_SW, 0, 4, "sw");
      directed(OP_BEQ, 0, 3, "beq");
      directed(OP_J, 0, 3, "j");
      idle_peek();
      check("five_retired", 64'(bus.retired), 64'd5);

      cur_opc = 6'b111111;
      build(6'b111111, 0, 0, 20);
      play(1000, n);
      check("halt_len", 64'(n), 64'd22);
      idle_peek();
      check("halt_flag", 64'(bus.halted), 64'd1);
      check("halt_retired", 64'(bus.retired), 64'd5);
      check("halt_state", 64'(bus.state), 64'd14);
      $display("directed halt opcode=111111 cycles=%0d", n);
      do_reset();

      // Reset during a store stall must drop mem_write without waiting for a clock.
      cur_opc = OP_SW;
      build(OP_SW, 0, 5, 0);
      play(5, n);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #3;
      check("stall_mem_write", 64'(bus.mem_write), 64'd1);
      reset = 1'b0;
      #1;
      check("async_mem_write", 64'(bus.mem_write), 64'd0);
      check("async_state", 64'(bus.state), 64'd0);
      $display("directed sw_stall_reset cycles=%0d", n);
      do_reset();

      for (int i = 0; i < 200; i++) begin
         int lim;
         if ($urandom_range(0, 24) == 0) begin
            do op = 6'($urandom); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 7)];
         end
         cur_opc = op;
         build(op, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(3, 6));
         lim = ($urandom_range(0, 11) == 0) ? $urandom_range(1, seq_q.size()) : 1000;
         play(lim, n);
         $display("instr %0d opcode=%b cycles=%0d%s", i, op, n,
                  (seq_q.size() > 0) ? " reset-abort" : "");
         if (seq_q.size() > 0 || !is_legal(op))
            do_reset();
      end

      @(negedge clk);
      bus.mem_ready = 1'b0;
      #5;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencing controller for the processor datapath. It replaces the single-cycle opcode decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- It shares one memory port between instruction and data accesses. It stalls on a memory-ready handshake and halts on an illegal opcode.
- It sits between the instruction register opcode field and the datapath multiplexers, register file, ALU control and PC.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
iord  output  1  memory address select (0=PC, 1=ALU result register)
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
reg_dst  output  1  destination select (1=rd, 0=rt)
mem_to_reg  output  1  writeback select (1=memory data register)
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=register A
alu_src_b  output  2  00=reg B, 01=constant 4, 10=sign-extended immediate, 11=immediate<<2
alu_op  output  2  00 add, 01 sub (beq), 10 funct-decoded, 11 and
pc_source  output  2  00=ALU result, 01=ALU output register, 10=jump target
instr_done  output  1  one-cycle pulse when an instruction retires
halted  output  1  high while in HALT
retired  output  CNT_W  retired-instruction count
state  output  4  current state encoding (debug)

Behaviour:
- Moore FSM. Outputs are a pure function of the state register, except that pc_write and ir_write in FETCH are qualified by mem_ready. Every output not listed for a state is 0, and no x is ever driven.
- Reset asserted (asynchronous): state=RST(0), retired=0, all outputs 0. The first rising edge after deassertion moves the FSM to FETCH.
- State encodings: RST 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EX 7, SH_EX 8, IMM_EX 9, R_WB 10, IMM_WB 11, BRANCH 12, JUMP 13, HALT 14. Encoding 15 is unreachable; if entered it goes to FETCH.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; on mem_ready=1 goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Latches opcode into opcode_q, then dispatches:
  - 000000 -> R_EX
  - 110000 -> SH_EX
  - 001000 or 001100 -> IMM_EX
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw (by opcode_q).
- MEM_RD: iord=1, mem_read=1. Holds while mem_ready=0; goes to MEM_WB on mem_ready.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Retires, then FETCH.
- MEM_WR: iord=1, mem_write=1. Holds while mem_ready=0; on mem_ready, retires and goes to FETCH.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- SH_EX: alu_src_a=1, alu_src_b=10, alu_op=10, then R_WB.
- R_WB: reg_dst=1, reg_write=1. Retires, then FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 11 for andi. Then IMM_WB.
- IMM_WB: reg_dst=0, reg_write=1. Retires, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires, then FETCH.
- JUMP: pc_write=1, pc_source=10. Retires, then FETCH.
- HALT: halted=1. Stays in HALT until reset; mem_ready is ignored. The halting instruction does not retire.
- Retire: instr_done=1 in the retiring state's cycle (Moore, decoded from state; for MEM_WR it is qualified by mem_ready). retired increments on the same edge that leaves the retiring state.
- Latency with zero wait states, in cycles including FETCH:
  - R-type, shift, addi, andi, sw: 4
  - lw: 5
  - beq, j: 3
  - Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds 1.
- mem_ready asserted outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset mid-instruction, including mid-stall: immediate return to RST. No write strobe may remain high during reset.

Decomposition:
- Shared package (e.g. cpu_pkg) holds:
  - opcode constants: OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_SHIFT
  - ALU_OP_* and ALU_SRC_B_* / PC_SRC_* encodings
  - the state enum
- One natural sub-module: mc_dispatch, the combinational DECODE next-state ROM (opcode -> next state). Everything else stays in multicycle_control.

Test Plan:
- Reset low for 3 cycles with mem_ready=1 -> all outputs 0, state=0; after release state goes 0->1, retired=0.
- opcode=000000, mem_ready=1 -> states 1,2,7,10. R_WB shows reg_dst=1, reg_write=1; instr_done pulses once and retired=1 after 4 cycles.
- opcode=100011, mem_ready low for 2 cycles in MEM_RD -> mem_read and iord hold high for 3 cycles. MEM_WB has mem_to_reg=1, reg_write=1; total 7 cycles.
- opcode=101011, mem_ready=1 -> MEM_WR for one cycle with mem_write=1, iord=1; no reg_write in any cycle; 4 cycles.
- opcode=000100 then 000010 -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01. JUMP shows pc_write=1, pc_source=10. Each takes 3 cycles.
- opcode=111111 -> HALT; halted=1 held for 20 cycles, retired unchanged. Reset asserted during a MEM_WR stall drops mem_write to 0 asynchronously.
